// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - BEQ direction predictor, EX resolution and mispredict flush sequencer
//
// Purpose:
//   IF stage : predicts branch direction from a table of 2-bit saturating
//              counters (BHT) indexed by pc[BHT_IDX+1:2].
//   EX stage : resolves taken = ex_zero for a live branch, trains the BHT
//              and, on a mispredict, issues a one-cycle PC redirect followed
//              by FLUSH_CYCLES cycles of IF/ID and ID/EX squash.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_pc, if_is_branch   IF instruction address and predecode branch flag
//   predict_taken         IF prediction (combinational read of the BHT)
//   ex_valid, ex_branch   EX holds a live instruction / it is a branch
//   ex_zero               ALU zero flag (branch outcome)
//   ex_pred_taken         prediction carried down the pipe with the branch
//   ex_pc, ex_target,
//   ex_pc_plus4           EX PC, taken target, fall-through address
//   pc_select             one-cycle redirect strobe to the PC mux
//   redirect_pc           corrected PC, held between redirects
//   flush_if_id,
//   flush_id_ex           pipeline register squash
//   busy                  sequencer is in its flush window
//   mispredict_cnt        saturating mispredict statistic

module branch_predict_ctrl #(
    parameter int XLEN         = 32,
    parameter int BHT_IDX      = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_is_branch,
    output logic             predict_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic [XLEN-1:0]  ex_pc_plus4,
    output logic             pc_select,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int BHT_N = 1 << BHT_IDX;
    localparam int FC_W  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [FC_W-1:0] flush_cnt;
    logic [FC_W-1:0] flush_cnt_next;

    logic [1:0] bht [BHT_N];

    logic [BHT_IDX-1:0] if_idx;
    logic [BHT_IDX-1:0] ex_idx;

    logic resolve;
    logic mispredict;

    assign if_idx = if_pc[BHT_IDX+1:2];
    assign ex_idx = ex_pc[BHT_IDX+1:2];

    // Only the index field of the PCs selects a counter; the rest is
    // deliberately ignored (aliasing between branches is accepted).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX+2], if_pc[1:0],
                              ex_pc[XLEN-1:BHT_IDX+2], ex_pc[1:0]};

    // Read returns the registered entry, so an update landing at the end of
    // this cycle is only visible from the next cycle on.
    assign predict_taken = if_is_branch & bht[if_idx][1];

    // ---------------------------------------------------------------
    // Sequencer: next state and flush outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        resolve        = 1'b0;
        mispredict     = 1'b0;
        busy           = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;

        case (state)
            IDLE: begin
                resolve    = ex_valid & ex_branch;
                mispredict = resolve & (ex_zero ^ ex_pred_taken);
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FC_LOAD;
                end
            end
            FLUSH: begin
                // EX contents are wrong-path while flushing: never resolved.
                busy           = 1'b1;
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
                flush_cnt_next = flush_cnt - FC_ONE;
                if (flush_cnt == FC_ONE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                flush_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // ---------------------------------------------------------------
    // Branch history table training
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (ex_zero) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Redirect strobe, corrected PC and statistics
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_select      <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            pc_select <= mispredict;
            if (mispredict) begin
                redirect_pc <= ex_zero ? ex_target : ex_pc_plus4;
                if (mispredict_cnt != CNT_MAX) begin
                    mispredict_cnt <= mispredict_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - self-checking bench for branch_predict_ctrl

module tb_branch_predict_ctrl;

    localparam int FLUSH_N = 2;
    localparam int CNT_SAT = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        predict_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_zero;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [31:0] ex_pc_plus4;
    logic        pc_select;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        busy;
    logic [15:0] mispredict_cnt;

    branch_predict_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_is_branch   (if_is_branch),
        .predict_taken  (predict_taken),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_zero        (ex_zero),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pc_plus4    (ex_pc_plus4),
        .pc_select      (pc_select),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .busy           (busy),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: counters as integers 0..3, the flush window as a
    // number of remaining squash cycles.
    int          m_bht [16];
    int          m_left;
    bit          m_psel;
    logic [31:0] m_redir;
    int          m_cnt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  idx;
        bit  live;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
            m_left  = 0;
            m_psel  = 0;
            m_redir = 0;
            m_cnt   = 0;
        end else begin
            live   = (m_left == 0) && ex_valid && ex_branch;
            m_psel = 0;
            if (m_left > 0) m_left--;
            if (live) begin
                idx = int'(ex_pc[5:2]);
                if (ex_zero) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                else         m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
                if (ex_zero != ex_pred_taken) begin
                    m_psel  = 1;
                    m_redir = ex_zero ? ex_target : ex_pc_plus4;
                    m_left  = FLUSH_N;
                    if (m_cnt < CNT_SAT) m_cnt++;
                end
            end
        end
    endtask

    task automatic compare();
        bit exp_pred;
        exp_pred = if_is_branch && (m_bht[int'(if_pc[5:2])] >= 2);
        chk("predict_taken",  {31'b0, predict_taken}, {31'b0, exp_pred});
        chk("pc_select",      {31'b0, pc_select},     {31'b0, m_psel});
        chk("redirect_pc",    redirect_pc,            m_redir);
        chk("flush_if_id",    {31'b0, flush_if_id},   (m_left > 0) ? 32'd1 : 32'd0);
        chk("flush_id_ex",    {31'b0, flush_id_ex},   (m_left > 0) ? 32'd1 : 32'd0);
        chk("busy",           {31'b0, busy},          (m_left > 0) ? 32'd1 : 32'd0);
        chk("mispredict_cnt", {16'b0, mispredict_cnt}, m_cnt);
    endtask

    // Inputs are set at the falling edge; outputs are compared 1 time unit
    // later, then the model advances across the rising edge.
    task automatic step();
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset         = 1'b0;
        if_pc         = 32'h0;
        if_is_branch  = 1'b0;
        ex_valid      = 1'b0;
        ex_branch     = 1'b0;
        ex_zero       = 1'b0;
        ex_pred_taken = 1'b0;
        ex_pc         = 32'h0;
        ex_target     = 32'h0;
        ex_pc_plus4   = 32'h0;
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic zero, input logic pred,
                              input logic [31:0] target);
        set_idle();
        ex_valid      = 1'b1;
        ex_branch     = 1'b1;
        ex_pc         = pc;
        ex_zero       = zero;
        ex_pred_taken = pred;
        ex_target     = target;
        ex_pc_plus4   = pc + 32'd4;
    endtask

    task automatic probe_pc(input logic [31:0] pc);
        set_idle();
        if_pc        = pc;
        if_is_branch = 1'b1;
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
        end
        set_idle();

        // Reset state: no prediction taken anywhere.
        step();
        for (int i = 0; i < 16; i++) begin
            probe_pc(32'(i * 4));
            chk("reset_predict", {31'b0, predict_taken}, 32'd0);
            step();
        end

        // Mispredicted taken branch at 0x10.
        set_branch(32'h10, 1'b1, 1'b0, 32'h40);
        step();
        set_idle();
        #1;
        chk("lit_psel",     {31'b0, pc_select},   32'd1);
        chk("lit_redirect", redirect_pc,          32'h40);
        chk("lit_flush1",   {31'b0, flush_if_id}, 32'd1);
        chk("lit_cnt1",     {16'b0, mispredict_cnt}, 32'd1);
        step();
        chk("lit_flush2",   {31'b0, flush_id_ex}, 32'd1);
        chk("lit_psel_off", {31'b0, pc_select},   32'd0);
        step();
        chk("lit_flush_end", {31'b0, busy},       32'd0);
        probe_pc(32'h10);
        chk("lit_pred_10", {31'b0, predict_taken}, 32'd1);
        step();

        // Correctly predicted taken twice: counter saturates at 3.
        for (int i = 0; i < 2; i++) begin
            set_branch(32'h10, 1'b1, 1'b1, 32'h40);
            step();
            set_idle();
            #1;
            chk("lit_no_psel", {31'b0, pc_select}, 32'd0);
            step();
        end

        // Not-taken mispredict at 0x20, then a wrong-path mispredict at 0x30.
        set_branch(32'h20, 1'b0, 1'b1, 32'h80);
        step();
        set_branch(32'h30, 1'b1, 1'b0, 32'h90);
        #1;
        chk("lit_redirect_24", redirect_pc, 32'h24);
        step();
        set_idle();
        step();
        step();
        chk("lit_cnt2", {16'b0, mispredict_cnt}, 32'd2);
        probe_pc(32'h30);
        chk("lit_pred_30_unchanged", {31'b0, predict_taken}, 32'd0);
        step();

        // Reset during the second flush cycle.
        set_branch(32'h10, 1'b0, 1'b1, 32'h40);
        step();
        set_idle();
        step();
        reset = 1'b1;
        #1;
        chk("lit_busy_before_rst", {31'b0, busy}, 32'd1);
        step();
        set_idle();
        #1;
        chk("lit_rst_busy",  {31'b0, busy},        32'd0);
        chk("lit_rst_flush", {31'b0, flush_if_id}, 32'd0);
        chk("lit_rst_cnt",   {16'b0, mispredict_cnt}, 32'd0);
        probe_pc(32'h10);
        chk("lit_rst_pred", {31'b0, predict_taken}, 32'd0);
        step();

        // Randomised traffic over a small PC set so entries collide and train.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            if_pc         = $urandom & 32'h7C;
            if_is_branch  = $urandom_range(0, 1);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_branch     = $urandom_range(0, 1);
            ex_zero       = $urandom_range(0, 1);
            ex_pc         = $urandom & 32'h7C;
            ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~ex_zero
                                                        : (m_bht[int'(ex_pc[5:2])] >= 2);
            ex_target     = $urandom;
            ex_pc_plus4   = ex_pc + 32'd4;
            step();
        end

        set_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
